// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter: saturation FSM states and mode encodings.
package counter_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SAT_HI = 2'd1,
    SAT_LO = 2'd2
  } cnt_state_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count / next-state / pulse calculation for updown_mod_counter.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_state_e       state,
  input  logic             enable,
  input  logic             load,
  input  logic             up_dn,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_next,
  output cnt_state_e       state_next,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  cnt_state_e eff_state;

  always_comb begin
    count_next = count;
    state_next = state;
    carry      = 1'b0;
    borrow     = 1'b0;
    load_err   = 1'b0;
    eff_state  = state;

    if (load) begin
      if (data_in > MAX_V) begin
        count_next = MAX_V;
        load_err   = 1'b1;
      end else begin
        count_next = data_in;
      end
      if (mode == MODE_SAT && count_next == MAX_V)
        state_next = SAT_HI;
      else if (mode == MODE_SAT && count_next == ZERO)
        state_next = SAT_LO;
      else
        state_next = RUN;
    end else if (enable) begin
      // Wrap mode never sits in a saturated state: fall straight back to RUN rules.
      eff_state  = (mode == MODE_WRAP) ? RUN : state;
      state_next = eff_state;
      case (eff_state)
        SAT_HI: begin
          if (!up_dn) begin
            count_next = count - ONE;
            state_next = RUN;
          end
        end
        SAT_LO: begin
          if (up_dn) begin
            count_next = count + ONE;
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          if (up_dn) begin
            if (count == MAX_V) begin
              carry = 1'b1;
              if (mode == MODE_WRAP) count_next = ZERO;
              else                   state_next = SAT_HI;
            end else begin
              count_next = count + ONE;
            end
          end else begin
            if (count == ZERO) begin
              borrow = 1'b1;
              if (mode == MODE_WRAP) count_next = MAX_V;
              else                   state_next = SAT_LO;
            end else begin
              count_next = count - ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX_VAL+1) counter with wrap/saturate modes, carry/borrow and load-range pulses.
// Optional registered compare output (Cmp_val/Match) when COUNTER_MATCH_EN is defined.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic             Up_dn,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Data_in,
`ifdef COUNTER_MATCH_EN
  input  logic [WIDTH-1:0] Cmp_val,
  output logic             Match,
`endif
  output logic [WIDTH-1:0] Count,
  output logic             C_out,
  output logic             B_out,
  output logic             Load_err,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_reg, count_next;
  cnt_state_e       state_reg, state_next;
  logic             c_reg, b_reg, err_reg;
  logic             c_next, b_next, err_next;

  counter_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next_val (
    .count      (count_reg),
    .state      (state_reg),
    .enable     (Enable),
    .load       (Load),
    .up_dn      (Up_dn),
    .mode       (Mode),
    .data_in    (Data_in),
    .count_next (count_next),
    .state_next (state_next),
    .carry      (c_next),
    .borrow     (b_next),
    .load_err   (err_next)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      state_reg <= RUN;
      c_reg     <= 1'b0;
      b_reg     <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      state_reg <= state_next;
      c_reg     <= c_next;
      b_reg     <= b_next;
      err_reg   <= err_next;
    end
  end

`ifdef COUNTER_MATCH_EN
  // Only a counting step can raise Match; loads and saturated holds leave the count unchanged or are excluded.
  logic match_reg;
  logic step_next;
  assign step_next = Enable && !Load && (count_next != count_reg);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) match_reg <= 1'b0;
    else       match_reg <= step_next && (count_next == Cmp_val);
  end

  assign Match = match_reg;
`endif

  assign Count    = count_reg;
  assign C_out    = c_reg;
  assign B_out    = b_reg;
  assign Load_err = err_reg;
  assign Tc       = (Up_dn && count_reg == MAX_V) || (!Up_dn && count_reg == '0);

endmodule
